ram_fill_checker: RTL and testbench

Upstream sequencer and checker for the 16-entry 4-bit RAM stage (F1 function bit plus 2-bit adder sum/carry written on WE).
- Sweeps every address, drives the RAM's W/X/Y/Z and Xi/Yi operand inputs from the address bits, and asserts WE to fill the RAM.
- Reads every address back through the RAM's asynchronous Do path and compares against an internally computed expected word.
- Reports pass/fail, error count and first failing address; used as a power-on self-test and retention check.

---
 rtl/ram_fill_pkg.sv | 27 ++
 rtl/ram_fill_checker_expect_gen.sv | 12 +
 rtl/ram_fill_checker.sv | 115 +++++++++++
 tb/tb_ram_fill_checker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ram_fill_pkg.sv
// Shared constants, state encoding and expected-word function for the RAM
// fill/verify sequencer.
package ram_fill_pkg;

  localparam int AW = 4;
  localparam int DW = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_WRITE = ST_WRITE,
    S_READ  = ST_READ,
    S_DONE  = ST_DONE
  } state_t;

  // bit0 is the F1 function of W/X/Y/Z, bits[3:1] the XI+YI sum with carry.
  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] addr);
    logic [2:0] sum;
    sum = {1'b0, addr[3:2]} + {1'b0, addr[1:0]};
    return {sum, addr[3] & addr[0] & ~(addr[2] ^ addr[1])};
  endfunction

endpackage

// File: rtl/ram_fill_checker_expect_gen.sv
// Combinational expected-word generator: the word the RAM stage should hold
// after being written with operands taken from its own address.
module ram_expect_gen
  import ram_fill_pkg::*;
(
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_exp
);

  assign o_exp = exp_word(i_addr);

endmodule

// File: rtl/ram_fill_checker.sv
// Power-on self-test sequencer: fills the RAM stage from the address bits,
// reads every word back and reports error count and first failing address.
module ram_fill_checker
  import ram_fill_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ERR_W = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             MODE,
  input  logic [DW-1:0]    DO,
  output logic             WE,
  output logic [AW-1:0]    A,
  output logic             W,
  output logic             X,
  output logic             Y,
  output logic             Z,
  output logic [1:0]       XI,
  output logic [1:0]       YI,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [AW-1:0]    FAIL_ADDR
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t            r_state, w_state_nx;
  logic [AW-1:0]     r_cnt, w_cnt_nx;
  logic [ERR_W-1:0]  r_err, w_err_nx;
  logic [AW-1:0]     r_fail, w_fail_nx;
  logic              r_first, w_first_nx;
  logic [DW-1:0]     w_exp;
  logic              w_wr;

  ram_expect_gen u_exp (
    .i_addr (r_cnt),
    .o_exp  (w_exp)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= '0;
      r_fail  <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_err   <= w_err_nx;
      r_fail  <= w_fail_nx;
      r_first <= w_first_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_err_nx   = r_err;
    w_fail_nx  = r_fail;
    w_first_nx = r_first;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (START) begin
          w_cnt_nx   = '0;
          w_err_nx   = '0;
          w_fail_nx  = '0;
          w_first_nx = 1'b0;
          w_state_nx = MODE ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_cnt == LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = S_READ;
        end else begin
          w_cnt_nx = r_cnt + AW'(1);
        end
      end
      S_READ: begin
        if (DO != w_exp) begin
          w_err_nx = r_err + ERR_W'(1);
          if (!r_first) begin
            w_fail_nx  = r_cnt;
            w_first_nx = 1'b1;
          end
        end
        // cnt is left at the last address; START clears it.
        if (r_cnt == LAST) w_state_nx = S_DONE;
        else               w_cnt_nx   = r_cnt + AW'(1);
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_wr      = (r_state == S_WRITE);
  assign WE        = w_wr;
  assign BUSY      = (r_state == S_WRITE) || (r_state == S_READ);
  assign A         = BUSY ? r_cnt : '0;
  assign W         = w_wr & r_cnt[3];
  assign X         = w_wr & r_cnt[2];
  assign Y         = w_wr & r_cnt[1];
  assign Z         = w_wr & r_cnt[0];
  assign XI        = w_wr ? r_cnt[3:2] : 2'b00;
  assign YI        = w_wr ? r_cnt[1:0] : 2'b00;
  assign DONE      = (r_state == S_DONE);
  assign PASS      = DONE && (r_err == '0);
  assign ERR_CNT   = r_err;
  assign FAIL_ADDR = r_fail;

endmodule

// File: tb/tb_ram_fill_checker.sv
// Bench for ram_fill_checker: behavioural RAM stage with fault injection,
// table-driven runs, corner-case sequences and randomized runs.
module tb_ram_fill_checker;

  logic       CLK = 1'b0;
  logic       RST_N, START, MODE;
  logic [3:0] DO;
  logic       WE, W, X, Y, Z, BUSY, DONE, PASS;
  logic [3:0] A, FAIL_ADDR;
  logic [1:0] XI, YI;
  logic [4:0] ERR_CNT;

  ram_fill_checker #(.DEPTH(16), .ERR_W(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE), .DO(DO),
    .WE(WE), .A(A), .W(W), .X(X), .Y(Y), .Z(Z), .XI(XI), .YI(YI),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT),
    .FAIL_ADDR(FAIL_ADDR)
  );

  always #5 CLK = ~CLK;

  // Behavioural RAM stage: F1 function bit plus 2-bit adder written on WE.
  logic [3:0]  mem [16];
  logic [3:0]  load_val [16];
  logic        load_req;
  logic [15:0] fault_map;
  logic [3:0]  fmask;
  logic [2:0]  sum_w;

  assign sum_w = {1'b0, XI} + {1'b0, YI};
  assign DO    = mem[A] ^ (fault_map[A] ? fmask : 4'h0);

  always @(posedge CLK) begin
    if (load_req) mem <= load_val;
    else if (WE) mem[A] <= {sum_w, W & Z & ~(X ^ Y)};
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int ref_exp(input int a);
    int f1;
    f1 = ((a / 8) % 2 == 1 && a % 2 == 1 && (a / 4) % 2 == (a / 2) % 2) ? 1 : 0;
    return 2 * ((a / 4) % 4 + a % 4) + f1;
  endfunction

  task automatic preload(input bit rnd);
    for (int i = 0; i < 16; i++) load_val[i] = rnd ? 4'($urandom) : 4'h0;
    load_req = 1'b1;
    @(posedge CLK); #1;
    load_req = 1'b0;
  endtask

  // START at edge 0; cycles counted including that edge until DONE is seen.
  task automatic run(input bit mode, input int poke, output int cyc,
                     output int we_cnt, output int seq_err);
    START = 1'b1; MODE = mode;
    @(posedge CLK); #1;
    START = 1'b0;
    cyc = 1; we_cnt = 0; seq_err = 0;
    while (!DONE && cyc < 100) begin
      if (!BUSY) seq_err++;
      if (WE) begin
        if (A != 4'(we_cnt) || W != A[3] || X != A[2] || Y != A[1] || Z != A[0] ||
            XI != A[3:2] || YI != A[1:0]) seq_err++;
        we_cnt++;
      end else if ({W, X, Y, Z, XI, YI} != 8'h0) seq_err++;
      START = (cyc == poke);
      if (cyc == poke) MODE = ~mode;
      @(posedge CLK); #1;
      START = 1'b0;
      cyc++;
    end
  endtask

  typedef struct {
    bit          mode;
    bit          clr;
    logic [15:0] fmap;
    logic [3:0]  fm;
    int          e_err;
    int          e_fail;
    int          e_cyc;
    int          e_we;
  } vec_t;

  vec_t tbl [5];

  task automatic check_run(input string tag, input int cyc, input int we_cnt,
                           input int seq_err, input int e_err, input int e_fail,
                           input int e_cyc, input int e_we);
    chk({tag, "_cycles"}, cyc, e_cyc);
    chk({tag, "_we_cycles"}, we_cnt, e_we);
    chk({tag, "_seq"}, seq_err, 0);
    chk({tag, "_done"}, int'(DONE), 1);
    chk({tag, "_err_cnt"}, int'(ERR_CNT), e_err);
    chk({tag, "_fail_addr"}, int'(FAIL_ADDR), e_fail);
    chk({tag, "_pass"}, int'(PASS), (e_err == 0) ? 1 : 0);
  endtask

  initial begin
    int cyc, we_cnt, seq_err, e_err, e_fail;
    int after [16];
    int rd;

    RST_N = 1'b0; START = 1'b0; MODE = 1'b0;
    load_req = 1'b0; fault_map = '0; fmask = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_we", int'(WE), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_pass", int'(PASS), 0);
    chk("rst_err", int'(ERR_CNT), 0);
    chk("rst_fail_addr", int'(FAIL_ADDR), 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    tbl[0] = '{1'b0, 1'b1, 16'h0000, 4'h0, 0, 0, 33, 16};   // golden fill + verify
    tbl[1] = '{1'b0, 1'b0, 16'h1020, 4'h4, 2, 5, 33, 16};   // bit2 faults at 5 and 12
    tbl[2] = '{1'b1, 1'b0, 16'h0000, 4'h0, 0, 0, 17, 0};    // retention, verify only
    tbl[3] = '{1'b1, 1'b1, 16'h0000, 4'h0, 15, 1, 17, 0};   // unwritten all-zero RAM
    tbl[4] = '{1'b0, 1'b0, 16'h8000, 4'h1, 1, 15, 33, 16};  // fault at last address

    for (int v = 0; v < 5; v++) begin
      if (tbl[v].clr) preload(1'b0);
      fault_map = tbl[v].fmap; fmask = tbl[v].fm;
      run(tbl[v].mode, -1, cyc, we_cnt, seq_err);
      check_run($sformatf("vec%0d", v), cyc, we_cnt, seq_err,
                tbl[v].e_err, tbl[v].e_fail, tbl[v].e_cyc, tbl[v].e_we);
      fault_map = '0; fmask = '0;
    end

    // START (with MODE flipped) during WRITE must be ignored.
    preload(1'b0);
    run(1'b0, 10, cyc, we_cnt, seq_err);
    check_run("start_busy", cyc, we_cnt, seq_err, 0, 0, 33, 16);

    // Asynchronous reset mid-write at A=7, then a clean rerun.
    preload(1'b0);
    START = 1'b1; MODE = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (WE && A == 4'd7) break;
      @(posedge CLK); #1;
    end
    chk("midrst_reached_a7", int'(WE && A == 4'd7), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_we", int'(WE), 0);
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_a", int'(A), 0);
    chk("midrst_partial6", int'(mem[6]), ref_exp(6));
    chk("midrst_untouched8", int'(mem[8]), 0);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    run(1'b0, -1, cyc, we_cnt, seq_err);
    check_run("after_rst", cyc, we_cnt, seq_err, 0, 0, 33, 16);

    // Randomized runs against an address-level model of the RAM contents.
    for (int r = 0; r < 20; r++) begin
      bit m;
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) preload(1'b1);
      fault_map = 16'($urandom & $urandom & $urandom);
      fmask = 4'($urandom_range(1, 15));
      for (int a = 0; a < 16; a++) after[a] = m ? int'(mem[a]) : ref_exp(a);
      e_err = 0; e_fail = -1;
      for (int a = 0; a < 16; a++) begin
        rd = after[a] ^ (fault_map[a] ? int'(fmask) : 0);
        if (rd != ref_exp(a)) begin
          e_err++;
          if (e_fail < 0) e_fail = a;
        end
      end
      if (e_fail < 0) e_fail = 0;
      run(m, -1, cyc, we_cnt, seq_err);
      check_run($sformatf("rnd%0d", r), cyc, we_cnt, seq_err, e_err, e_fail,
                m ? 17 : 33, m ? 0 : 16);
      fault_map = '0; fmask = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
